dms_lpf_casc: RTL and testbench

Parametrised cascaded real-pole low-pass filter for the DMS real-number-model library. It generalises the fixed two-pole, internally clocked trim filter to NPOLE bilinear first-order sections clocked by an external sample clock. Each pole has its own trim scaling. Trim changes are applied glitch-free through a shadow-coefficient state machine, and the block adds output clipping, bypass and a valid flag. It sits in analog front-end models between a wreal1driver source and downstream sampling or CDR logic.

---
 rtl/cds_rnm_pkg.sv | 6 +
 rtl/dms_lpf_casc_pkg.sv | 35 +++
 rtl/dms_lpf_casc_stage.sv | 32 +++
 rtl/dms_lpf_casc.sv | 174 +++++++++++++++++
 tb/tb_dms_lpf_casc.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cds_rnm_pkg.sv
// Minimal stand-in for the simulator's RNM library: a single-driver
// real-valued net type mapped onto plain real for portable simulation.
`timescale 1ns/1ps
package cds_rnm_pkg;
    typedef real wreal1driver;
endpackage

// File: rtl/dms_lpf_casc_pkg.sv
// Shared types and helpers for the DMS cascaded low-pass filter:
// FSM states, section coefficient bundle and coefficient math.
`timescale 1ns/1ps
package dms_filt_pkg;

    localparam real M_TWO_PI = 6.283185307179586;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } lpf_state_e;

    typedef struct {
        real b;
        real c;
    } lpf_coef_t;

    // Bilinear first-order section coefficients for pole f at period ts
    function automatic lpf_coef_t calc_coef(real f, real ts);
        lpf_coef_t r;
        real a;
        a = M_TWO_PI * f * ts;
        r.b = a / (a + 2.0);
        r.c = (2.0 - a) / (a + 2.0);
        return r;
    endfunction

    // Undriven, contended or out-of-range samples (NaN, >= 1e20) read as 0.0
    function automatic real rnm_clean(real v);
        if ((v != v) || (v >= 1.0e20)) return 0.0;
        return v;
    endfunction

endpackage

// File: rtl/dms_lpf_casc_stage.sv
// One bilinear first-order low-pass section:
// y = b*(x + x_prev) + c*y_prev, advanced only on enabled samples.
`timescale 1ns/1ps
module dms_lpf1_stage
    import dms_filt_pkg::*;
#(
    parameter real Y_INIT = 0.0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  real       x_in,
    input  lpf_coef_t coef,
    output real       y_out
);

    real x_prev;
    real y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_prev <= Y_INIT;
            y      <= Y_INIT;
        end else if (en) begin
            y      <= coef.b * (x_in + x_prev) + coef.c * y;
            x_prev <= x_in;
        end
    end

    assign y_out = y;

endmodule

// File: rtl/dms_lpf_casc.sv
// Cascaded real-pole LPF with per-pole trim, glitch-free shadow
// coefficient update, output clip, bypass and valid flag.
`timescale 1ns/1ps
module dms_lpf_casc
    import dms_filt_pkg::*;
    import cds_rnm_pkg::*;
#(
    parameter int  NPOLE             = 2,
    parameter int  TRIM_W            = 4,
    parameter real Ts                = 1.0e-9,
    parameter real FPOLE     [NPOLE] = '{150.0e3, 500.0e3},
    parameter real TRIM_STEP [NPOLE] = '{12.5e3, 50.0e3},
    parameter real FMIN              = 1.0e3,
    parameter real VCLIP             = 10.0,
    parameter real Y_INIT            = 0.0
) (
    input  logic              clk,
    input  logic              rst,
    input  wreal1driver       IN,
    input  wreal1driver       Av,
    input  logic [TRIM_W-1:0] trim,
    input  logic              en,
    input  logic              bypass,
    output wreal1driver       OUT,
    output logic              out_valid,
    output logic              coef_busy
);

    localparam int IW = (NPOLE > 1) ? $clog2(NPOLE) : 1;
    localparam int VW = $clog2(NPOLE + 2);
    localparam logic [IW-1:0] LAST = IW'(NPOLE - 1);
    localparam logic [VW-1:0] VMAX = VW'(NPOLE + 1);

    lpf_state_e        state;
    lpf_state_e        state_nx;
    logic [TRIM_W-1:0] trim_applied;
    logic [TRIM_W-1:0] trim_target;
    logic [IW-1:0]     idx;
    logic              lat_target;
    logic              calc_en;
    logic              commit;

    lpf_coef_t active   [NPOLE];
    lpf_coef_t shadow   [NPOLE];
    lpf_coef_t coef_use [NPOLE];

    real              x_reg;
    real              byp_reg;
    real              y_sec [NPOLE];
    real              y_clip;
    real              out_int;
    logic [VW-1:0]    vcnt;

    function automatic real pole_freq(int k, logic [TRIM_W-1:0] t);
        real f;
        f = FPOLE[k] + real'(t) * TRIM_STEP[k];
        return (f < FMIN) ? FMIN : f;
    endfunction

    always_comb begin
        state_nx   = state;
        lat_target = 1'b0;
        calc_en    = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (trim != trim_applied) begin
                    state_nx   = CALC;
                    lat_target = 1'b1;
                end
            end
            CALC: begin
                // A moving target restarts the sweep from section 0
                if (trim != trim_target) begin
                    lat_target = 1'b1;
                end else begin
                    calc_en = 1'b1;
                    if (idx == LAST) state_nx = COMMIT;
                end
            end
            COMMIT: begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            trim_target  <= '0;
            trim_applied <= '0;
            for (int k = 0; k < NPOLE; k++) begin
                active[k] <= calc_coef(pole_freq(k, '0), Ts);
                shadow[k] <= calc_coef(pole_freq(k, '0), Ts);
            end
        end else begin
            state <= state_nx;
            if (lat_target) begin
                trim_target <= trim;
                idx         <= '0;
            end else if (calc_en) begin
                shadow[idx] <= calc_coef(pole_freq(int'(idx), trim_target), Ts);
                idx         <= idx + IW'(1);
            end
            if (commit) begin
                trim_applied <= trim_target;
                for (int k = 0; k < NPOLE; k++) active[k] <= shadow[k];
            end
        end
    end

    // Sections see the shadow set on the commit edge so all switch together
    always_comb begin
        for (int k = 0; k < NPOLE; k++) begin
            coef_use[k] = (state == COMMIT) ? shadow[k] : active[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg   <= Y_INIT;
            byp_reg <= Y_INIT;
            vcnt    <= '0;
        end else if (en) begin
            x_reg   <= rnm_clean(IN);
            byp_reg <= x_reg;
            if (vcnt != VMAX) vcnt <= vcnt + VW'(1);
        end
    end

    for (genvar k = 0; k < NPOLE; k++) begin : g_sec
        if (k == 0) begin : g_first
            dms_lpf1_stage #(
                .Y_INIT (Y_INIT)
            ) u_sec (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .x_in  (x_reg),
                .coef  (coef_use[k]),
                .y_out (y_sec[k])
            );
        end else begin : g_rest
            dms_lpf1_stage #(
                .Y_INIT (Y_INIT)
            ) u_sec (
                .clk   (clk),
                .rst   (rst),
                .en    (en),
                .x_in  (y_sec[k-1]),
                .coef  (coef_use[k]),
                .y_out (y_sec[k])
            );
        end
    end

    always_comb begin
        y_clip = y_sec[NPOLE-1];
        if (y_clip > VCLIP) begin
            y_clip = VCLIP;
        end else if (y_clip < -VCLIP) begin
            y_clip = -VCLIP;
        end
        out_int = bypass ? byp_reg : y_clip;
    end

    assign OUT       = out_int * Av;
    assign out_valid = (vcnt == VMAX);
    assign coef_busy = (state != IDLE);

endmodule

// File: tb/tb_dms_lpf_casc.sv
// Bench for dms_lpf_casc: directed sequences, a bypass vector table
// and a randomized run against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_dms_lpf_casc;

    localparam int NP = 2;
    localparam real PI2 = 2.0 * 3.141592653589793;
    localparam real TS = 1.0e-9;

    logic       clk = 1'b0;
    logic       rst;
    real        IN;
    real        Av;
    logic [3:0] trim;
    logic       en;
    logic       bypass;
    real        OUT;
    logic       out_valid;
    logic       coef_busy;

    int total = 0;
    int bad = 0;

    real fp [NP] = '{150.0e3, 500.0e3};
    real st [NP] = '{12.5e3, 50.0e3};

    dms_lpf_casc #(.NPOLE(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .IN        (IN),
        .Av        (Av),
        .trim      (trim),
        .en        (en),
        .bypass    (bypass),
        .OUT       (OUT),
        .out_valid (out_valid),
        .coef_busy (coef_busy)
    );

    always #0.5 clk = ~clk;

    // ---------------- behavioural model ----------------
    real  m_xr, m_byp;
    real  m_y [NP];
    real  m_xp [NP];
    real  m_b [NP];
    real  m_c [NP];
    logic m_busy;
    int   m_target, m_applied, m_cnt;
    longint m_edge, m_commit;

    function automatic real coef_b(int k, int t);
        real f, a;
        f = fp[k] + t * st[k];
        if (f < 1.0e3) f = 1.0e3;
        a = PI2 * f * TS;
        return a / (a + 2.0);
    endfunction

    function automatic real coef_c(int k, int t);
        real f, a;
        f = fp[k] + t * st[k];
        if (f < 1.0e3) f = 1.0e3;
        a = PI2 * f * TS;
        return (2.0 - a) / (a + 2.0);
    endfunction

    function automatic real clean(real v);
        if ((v != v) || (v >= 1.0e20)) return 0.0;
        return v;
    endfunction

    task automatic load_coefs(int t);
        for (int k = 0; k < NP; k++) begin
            m_b[k] = coef_b(k, t);
            m_c[k] = coef_c(k, t);
        end
    endtask

    task automatic model_reset();
        m_xr = 0.0;
        m_byp = 0.0;
        for (int k = 0; k < NP; k++) begin
            m_y[k] = 0.0;
            m_xp[k] = 0.0;
        end
        load_coefs(0);
        m_busy = 1'b0;
        m_target = 0;
        m_applied = 0;
        m_cnt = 0;
        m_edge = 0;
        m_commit = 0;
    endtask

    task automatic model_edge();
        real inp [NP];
        m_edge++;
        if (m_busy && m_edge == m_commit) begin
            load_coefs(m_target);
            m_applied = m_target;
            m_busy = 1'b0;
        end else if (m_busy && int'(trim) != m_target) begin
            m_target = int'(trim);
            m_commit = m_edge + NP + 1;
        end else if (!m_busy && int'(trim) != m_applied) begin
            m_busy = 1'b1;
            m_target = int'(trim);
            m_commit = m_edge + NP + 1;
        end
        if (en) begin
            inp[0] = m_xr;
            for (int k = 1; k < NP; k++) inp[k] = m_y[k-1];
            for (int k = 0; k < NP; k++) begin
                m_y[k] = m_b[k] * (inp[k] + m_xp[k]) + m_c[k] * m_y[k];
                m_xp[k] = inp[k];
            end
            m_byp = m_xr;
            m_xr = clean(IN);
            if (m_cnt < NP + 1) m_cnt++;
        end
    endtask

    function automatic real model_out();
        real v;
        v = m_y[NP-1];
        if (v > 10.0) v = 10.0;
        if (v < -10.0) v = -10.0;
        if (bypass) v = m_byp;
        return v * Av;
    endfunction

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_edge();
    end

    always @(posedge rst) model_reset();

    // ---------------- checking helpers ----------------
    task automatic check_real(string name, real act, real exp, real tol);
        real d;
        total++;
        d = act - exp;
        if (d < 0.0) d = -d;
        if ((act != act) || d > tol) begin
            bad++;
            $display("FAIL %s: got %g want %g", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cmp_model(string name);
        real e;
        e = model_out();
        check_real({name, "_out"}, OUT, e, 1.0e-9 * (1.0 + (e < 0 ? -e : e)));
        check_int({name, "_valid"}, int'(out_valid), int'(m_cnt >= NP + 1));
        check_int({name, "_busy"}, int'(coef_busy), int'(m_busy));
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    typedef struct {
        real in_v;
        real av_v;
        real exp_v;
    } byp_vec_t;

    byp_vec_t vt [6];

    initial begin
        real nan_v, prev, dmax, d, exp_imp;
        int  nbusy;
        logic first_busy;

        nan_v = $bitstoreal(64'h7ff8_0000_0000_0000);
        vt[0] = '{0.3, 1.0, 0.3};
        vt[1] = '{-2.5, 2.0, -5.0};
        vt[2] = '{20.0, 1.0, 20.0};
        vt[3] = '{nan_v, 1.0, 0.0};
        vt[4] = '{1.0e25, 3.0, 0.0};
        vt[5] = '{7.0, -0.5, -3.5};

        model_reset();
        rst = 1'b1;
        IN = 0.0;
        Av = 1.0;
        trim = 4'd0;
        en = 1'b0;
        bypass = 1'b0;
        tick(2);
        check_real("reset_out", OUT, 0.0, 0.0);
        check_int("reset_valid", int'(out_valid), 0);
        check_int("reset_busy", int'(coef_busy), 0);
        rst = 1'b0;

        // DC step
        en = 1'b1;
        IN = 1.0;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            if (i <= 2) check_real("dc_zero", OUT, 0.0, 0.0);
            check_int("dc_valid", int'(out_valid), int'(i >= 3));
        end
        tick(15000);
        check_real("dc_settle", OUT, 1.0, 1.0e-3);
        cmp_model("dc");

        // Impulse latency and amplitude
        do_reset();
        IN = 1.0;
        tick(1);
        IN = 0.0;
        tick(1);
        check_real("imp_edge1", OUT, 0.0, 0.0);
        tick(1);
        exp_imp = coef_b(0, 0) * coef_b(1, 0);
        check_real("imp_edge2", OUT, exp_imp, exp_imp * 1.0e-3);
        cmp_model("imp");

        // Trim 0 -> 8
        IN = 1.0;
        tick(200);
        trim = 4'd8;
        prev = OUT;
        dmax = 0.0;
        nbusy = 0;
        first_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (i == 0) first_busy = coef_busy;
            if (coef_busy) nbusy++;
            d = OUT - prev;
            if (d < 0.0) d = -d;
            if (d > dmax) dmax = d;
            prev = OUT;
            cmp_model("trim8");
        end
        check_int("trim8_first_busy", int'(first_busy), 1);
        check_int("trim8_busy_cycles", nbusy, 3);
        check_int("trim8_applied", int'(dut.trim_applied), 8);
        check_real("trim8_step", dmax, 0.0, 1.0e-3);

        // Trim change during CALC restarts the sweep
        trim = 4'd4;
        tick(1);
        trim = 4'd6;
        nbusy = 1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (coef_busy) nbusy++;
            cmp_model("restart");
        end
        check_int("restart_busy_cycles", nbusy, 4);
        check_int("restart_applied", int'(dut.trim_applied), 6);

        // Hazard: undefined input, then clipping
        IN = nan_v;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_int("nan_out_defined", int'(OUT == OUT), 1);
            cmp_model("nan");
        end
        IN = 20.0;
        Av = 2.0;
        tick(15000);
        check_real("clip_settle", OUT, 20.0, 1.0e-3);
        cmp_model("clip");

        // Reset mid-CALC
        trim = 4'd3;
        tick(1);
        check_int("calc_busy", int'(coef_busy), 1);
        rst = 1'b1;
        #0.1;
        check_real("rst_mid_out", OUT, 0.0, 0.0);
        check_int("rst_mid_busy", int'(coef_busy), 0);
        check_int("rst_mid_valid", int'(out_valid), 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check_int("post_rst_calc", int'(coef_busy), 1);

        // Bypass vector table
        Av = 1.0;
        bypass = 1'b1;
        foreach (vt[i]) begin
            IN = vt[i].in_v;
            Av = vt[i].av_v;
            tick(2);
            check_real($sformatf("byp_vec%0d", i), OUT, vt[i].exp_v, 1.0e-12);
            cmp_model("byp");
        end
        bypass = 1'b0;
        Av = 1.0;

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 5)
                IN = real'(int'($urandom_range(0, 5000)) - 2500) / 100.0;
            if ($urandom_range(0, 99) < 2)
                Av = real'(int'($urandom_range(0, 400)) - 200) / 100.0;
            if ($urandom_range(0, 99) < 2)
                trim = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 3)
                bypass = ~bypass;
            en = ($urandom_range(0, 99) < 85);
            tick(1);
            cmp_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
